bp_dout_engine: RTL and testbench
=================================

Name: bp_dout_engine

Overview:
- Parametrised LSTM backprop engine. Computes the delta-out / dX vector for one layer and one timestep: dout[k] = sum over g in {a,i,f,o} and j in 0..N_CELL-1 of dgate[g][j] * W[g][j][k].
- Buffers the gate deltas from the delta unit, sequences weight-memory reads and drives an internal MAC.
- Streams results to the dout/dX memories over a valid/ready handshake.
- Generalises the fixed-size, externally sequenced MAC path into a self-sequenced block that can be sized for any layer.

Parameters:
- WIDTH, 24, data width of dgates, weights and results (signed fixed point).
- FRAC, 20, fractional bits.
- N_CELL, 8, cells in the producing layer (j range).
- N_OUT, 53, result vector length (k range).
- GUARD, 8, extra accumulator MSBs; ACC_W = WIDTH+GUARD.
- ADDR_W, 12, weight address width; must satisfy 2^ADDR_W >= 4*N_CELL*N_OUT.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- i_start  in  1  start pulse; honoured only in IDLE.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse when the last result is accepted.
- i_dg_valid  in  1  dgate stream valid.
- o_dg_ready  out  1  high only in LOAD.
- i_dg_data  in  WIDTH  dgate value. Order: n = g*N_CELL + j, with g = 0:a, 1:i, 2:f, 3:o.
- o_w_rd  out  1  weight read strobe.
- o_w_addr  out  ADDR_W  weight address = (g*N_CELL + j)*N_OUT + k.
- i_w_data  in  WIDTH  weight data, valid exactly 1 cycle after o_w_rd.
- o_dout_valid  out  1  result valid.
- i_dout_ready  in  1  result accepted when valid & ready.
- o_dout_data  out  WIDTH  result value.
- o_dout_idx  out  ADDR_W  result index k.
- o_sat  out  1  sticky saturation flag; cleared on start (exists only with BP_SAT_EN).

Behaviour:
- Reset (async, rst=1): state IDLE; all counters, accumulator and dgate buffer are cleared. All outputs are 0, including o_sat. Asserting rst mid-operation aborts the run immediately; no o_done is produced.
- IDLE: i_start moves to LOAD and clears o_sat. i_start in any other state is ignored.
- LOAD: o_dg_ready=1. Each valid&ready beat writes buffer[n] and increments n. After beat 4*N_CELL-1 the next state is MAC with k=0.
- MAC, for each k:
  - Issues 4*N_CELL consecutive reads (o_w_rd=1) for n = 0..4*N_CELL-1, with no bubbles. The accumulator is zeroed on the first issue cycle.
  - One cycle after each issue: p = buffer[n] * i_w_data (2*WIDTH signed), then p >>> FRAC (arithmetic, truncates toward -inf), sign-extended to ACC_W and added to the accumulator.
  - The cycle after the last issue completes the final add, then the state moves to OUT.
  - Compute latency per k is 4*N_CELL+1 cycles from the first issue to OUT entry.
- OUT: o_dout_valid=1; o_dout_data and o_dout_idx=k are held stable until i_dout_ready.
  - On acceptance with k < N_OUT-1: k++ and return to MAC on the next cycle.
  - On acceptance with k = N_OUT-1: o_done pulses and the state returns to IDLE.
- Boundaries:
  - o_w_rd=0 outside MAC issue cycles; o_w_addr holds its last value.
  - i_dg_valid outside LOAD is ignored.
  - Back-pressure in OUT stalls indefinitely without losing data.
  - The accumulator never wraps internally within ACC_W for legal GUARD.
- Output width reduction from ACC_W to WIDTH is defined under Optional Feature.

Optional Feature:
- Macro BP_SAT_EN.
- Defined: the result is clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. Any clamp sets o_sat, which stays set until the next accepted start or reset.
- Undefined: the result is the low WIDTH bits of the accumulator (two's-complement wrap). The o_sat port is absent.

Test Plan (N_CELL=2, N_OUT=3, WIDTH=24, FRAC=20; 1.0 = 0x100000):
- All dgates = 1.0, all weights = 0.5 (0x080000) -> three results of 4.0 (0x400000) with idx 0,1,2, one o_done pulse. Per k, o_w_addr sequence is k, k+3, k+6, ..., k+21.
- dgate n = n*0.125, W = -1.0 everywhere -> each result = -(0+...+7)*0.125 = -3.5 (0xC80000). Checks sign handling and >>> truncation.
- All dgates = 7.0, W = 7.0 -> true sum 392.0. With BP_SAT_EN: 0x7FFFFF and o_sat=1. Without: low 24 bits of the accumulator (0x800000).
- i_dout_ready held low for 10 cycles at k=1 -> o_dout_data and o_dout_idx stable throughout; no further o_w_rd until acceptance; final results unchanged.
- rst asserted during MAC at k=1 -> next cycle busy=0, all outputs 0. A new start then reloads the buffer and produces correct results from idx 0.
- i_start pulsed during LOAD and OUT, and i_dg_valid in IDLE -> no effect; exactly 8 beats accepted per run.

Source files
------------

// File: rtl/bp_dout_engine.sv
// LSTM backprop delta-out engine: dout[k] = sum_n dgate[n] * W[n][k], with n = g*N_CELL + j.
// Optional macro BP_SAT_EN: clamp results to WIDTH bits and expose the sticky o_sat flag.
module bp_dout_engine #(
  parameter int WIDTH  = 24,
  parameter int FRAC   = 20,
  parameter int N_CELL = 8,
  parameter int N_OUT  = 53,
  parameter int GUARD  = 8,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  input  logic              i_dg_valid,
  output logic              o_dg_ready,
  input  logic [WIDTH-1:0]  i_dg_data,
  output logic              o_w_rd,
  output logic [ADDR_W-1:0] o_w_addr,
  input  logic [WIDTH-1:0]  i_w_data,
  output logic              o_dout_valid,
  input  logic              i_dout_ready,
  output logic [WIDTH-1:0]  o_dout_data,
`ifdef BP_SAT_EN
  output logic [ADDR_W-1:0] o_dout_idx,
  output logic              o_sat
`else
  output logic [ADDR_W-1:0] o_dout_idx
`endif
);

  localparam int ACC_W = WIDTH + GUARD;
  localparam int NG    = 4 * N_CELL;
  localparam int NW    = $clog2(NG);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_MAC  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t                    state_q;
  logic [NW-1:0]             n_q;
  logic                      pend_q;
  logic [NW-1:0]             pend_n_q;
  logic [ADDR_W-1:0]         k_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic [WIDTH-1:0]          buf_q [NG];
  logic                      busy_q;
  logic                      done_q;
  logic                      dg_ready_q;
  logic                      w_rd_q;
  logic [ADDR_W-1:0]         w_addr_q;
  logic                      dout_valid_q;
  logic [WIDTH-1:0]          dout_data_q;
  logic [ADDR_W-1:0]         dout_idx_q;

  logic signed [2*WIDTH-1:0] prod_d;
  logic signed [ACC_W-1:0]   term_d;
  logic signed [ACC_W-1:0]   acc_d;
  logic [WIDTH-1:0]          dout_d;

`ifdef BP_SAT_EN
  logic                      sat_q;
  logic                      sat_d;

  // True when the accumulator does not fit in WIDTH signed bits.
  function automatic logic sat_hit(input logic [ACC_W-1:0] a);
    sat_hit = !((&a[ACC_W-1:WIDTH-1]) || !(|a[ACC_W-1:WIDTH-1]));
  endfunction

  function automatic logic [WIDTH-1:0] sat_val(input logic [ACC_W-1:0] a);
    if (sat_hit(a)) begin
      sat_val = a[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      sat_val = a[WIDTH-1:0];
    end
  endfunction
`endif

  // MAC datapath: product of the buffered dgate and returning weight, rescaled and accumulated.
  always_comb begin
    prod_d = $signed(buf_q[pend_n_q]) * $signed(i_w_data);
    term_d = ACC_W'(prod_d >>> FRAC);
    acc_d  = acc_q + term_d;
`ifdef BP_SAT_EN
    dout_d = sat_val(acc_d);
    sat_d  = sat_hit(acc_d);
`else
    dout_d = acc_d[WIDTH-1:0];
`endif
  end

  // Sequencer: load dgates, issue weight reads per k, accumulate, then hand off each result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      n_q          <= '0;
      pend_q       <= 1'b0;
      pend_n_q     <= '0;
      k_q          <= '0;
      acc_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      dg_ready_q   <= 1'b0;
      w_rd_q       <= 1'b0;
      w_addr_q     <= '0;
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
      dout_idx_q   <= '0;
`ifdef BP_SAT_EN
      sat_q        <= 1'b0;
`endif
      for (int i = 0; i < NG; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      pend_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_q    <= ST_LOAD;
            busy_q     <= 1'b1;
            dg_ready_q <= 1'b1;
            n_q        <= '0;
`ifdef BP_SAT_EN
            sat_q      <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          if (i_dg_valid) begin
            buf_q[n_q] <= i_dg_data;
            if (n_q == NW'(NG-1)) begin
              state_q    <= ST_MAC;
              dg_ready_q <= 1'b0;
              n_q        <= '0;
              k_q        <= '0;
              w_rd_q     <= 1'b1;
              w_addr_q   <= '0;
            end else begin
              n_q <= n_q + NW'(1);
            end
          end
        end
        ST_MAC: begin
          pend_q   <= w_rd_q;
          pend_n_q <= n_q;
          // Data returns one cycle after each issue; the first issue clears the sum.
          if (pend_q) begin
            acc_q <= acc_d;
          end else if (w_rd_q && (n_q == '0)) begin
            acc_q <= '0;
          end
          if (w_rd_q) begin
            if (n_q == NW'(NG-1)) begin
              w_rd_q <= 1'b0;
            end else begin
              n_q      <= n_q + NW'(1);
              w_addr_q <= w_addr_q + ADDR_W'(N_OUT);
            end
          end
          if (pend_q && (pend_n_q == NW'(NG-1))) begin
            state_q      <= ST_OUT;
            dout_valid_q <= 1'b1;
            dout_data_q  <= dout_d;
            dout_idx_q   <= k_q;
`ifdef BP_SAT_EN
            if (sat_d) begin
              sat_q <= 1'b1;
            end
`endif
          end
        end
        ST_OUT: begin
          if (i_dout_ready) begin
            dout_valid_q <= 1'b0;
            if (k_q == ADDR_W'(N_OUT-1)) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q  <= ST_MAC;
              k_q      <= k_q + ADDR_W'(1);
              n_q      <= '0;
              w_rd_q   <= 1'b1;
              w_addr_q <= k_q + ADDR_W'(1);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_dg_ready   = dg_ready_q;
  assign o_w_rd       = w_rd_q;
  assign o_w_addr     = w_addr_q;
  assign o_dout_valid = dout_valid_q;
  assign o_dout_data  = dout_data_q;
  assign o_dout_idx   = dout_idx_q;
`ifdef BP_SAT_EN
  assign o_sat        = sat_q;
`endif

endmodule

// File: tb/tb_bp_dout_engine.sv
// Scoreboard bench for bp_dout_engine with N_CELL=2, N_OUT=3 (8 dgates, 3 results per run).
module tb_bp_dout_engine;

  localparam int WIDTH = 24;
  localparam int FRAC  = 20;
  localparam int NC    = 2;
  localparam int NO    = 3;
  localparam int NG    = 4 * NC;
  localparam int AW    = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_start;
  logic             o_busy;
  logic             o_done;
  logic             i_dg_valid;
  logic             o_dg_ready;
  logic [WIDTH-1:0] i_dg_data;
  logic             o_w_rd;
  logic [AW-1:0]    o_w_addr;
  logic [WIDTH-1:0] i_w_data;
  logic             o_dout_valid;
  logic             i_dout_ready;
  logic [WIDTH-1:0] o_dout_data;
  logic [AW-1:0]    o_dout_idx;
`ifdef BP_SAT_EN
  logic             o_sat;
`endif

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  logic [WIDTH-1:0] dgv  [NG];
  logic [WIDTH-1:0] wmem [NG*NO];
  logic [WIDTH-1:0] exp_data_q [$];
  logic [AW-1:0]    exp_idx_q  [$];
  logic [AW-1:0]    exp_addr_q [$];
  logic [AW-1:0]    addr_exp;

  bp_dout_engine #(
    .WIDTH(WIDTH), .FRAC(FRAC), .N_CELL(NC), .N_OUT(NO), .GUARD(8), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
    .i_dg_valid(i_dg_valid), .o_dg_ready(o_dg_ready), .i_dg_data(i_dg_data),
    .o_w_rd(o_w_rd), .o_w_addr(o_w_addr), .i_w_data(i_w_data),
    .o_dout_valid(o_dout_valid), .i_dout_ready(i_dout_ready), .o_dout_data(o_dout_data),
`ifdef BP_SAT_EN
    .o_sat(o_sat),
`endif
    .o_dout_idx(o_dout_idx)
  );

  always #5 clk = ~clk;

  // Weight memory: synchronous read, data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (o_w_rd) i_w_data <= (int'(o_w_addr) < NG*NO) ? wmem[o_w_addr[4:0]] : '0;
  end

  // Address scoreboard: every strobe must match the next expected address.
  always @(negedge clk) begin
    if (!rst && o_w_rd) begin
      checks++;
      if (exp_addr_q.size() == 0) begin
        errors++;
        $display("FAIL w_addr: got read of %0d, required no read", o_w_addr);
      end else begin
        addr_exp = exp_addr_q.pop_front();
        if (o_w_addr !== addr_exp) begin
          errors++;
          $display("FAIL w_addr: got %0d, required %0d", o_w_addr, addr_exp);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (o_done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got still running, required finished");
    $fatal(1, "watchdog");
  end

  function automatic void push_addrs();
    for (int k = 0; k < NO; k++)
      for (int n = 0; n < NG; n++) exp_addr_q.push_back(AW'(n*NO + k));
  endfunction

  function automatic void push_const(input logic [WIDTH-1:0] v);
    for (int k = 0; k < NO; k++) begin
      exp_data_q.push_back(v);
      exp_idx_q.push_back(AW'(k));
    end
  endfunction

  // Reference arithmetic for arbitrary data: floor-shifted products summed, then reduced.
  function automatic void push_model();
    longint acc, a, b;
    for (int k = 0; k < NO; k++) begin
      acc = 0;
      for (int n = 0; n < NG; n++) begin
        a = longint'($signed(dgv[n]));
        b = longint'($signed(wmem[n*NO + k]));
        acc += (a * b) >>> FRAC;
      end
`ifdef BP_SAT_EN
      if (acc > 64'sd8388607) acc = 64'sd8388607;
      else if (acc < -64'sd8388608) acc = -64'sd8388608;
`endif
      exp_data_q.push_back(WIDTH'(acc));
      exp_idx_q.push_back(AW'(k));
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1; i_start = 1'b0; i_dg_valid = 1'b0; i_dg_data = '0; i_dout_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_job(input bit poke_start);
    int n = 0;
    int cyc = 0;
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    while (n < NG && cyc < 100) begin
      @(negedge clk);
      cyc++;
      i_dg_valid = 1'b1;
      i_dg_data  = dgv[n];
      i_start    = poke_start && (n == 3);
      if (o_dg_ready) n++;
    end
    @(negedge clk);
    i_dg_valid = 1'b0; i_start = 1'b0;
    if (n < NG) begin
      checks++; errors++;
      $display("FAIL load: got %0d beats accepted, required %0d", n, NG);
    end
  endtask

  task automatic collect(input int stall_k, input bit poke_start);
    logic [WIDTH-1:0] ed;
    logic [AW-1:0]    ei;
    for (int k = 0; k < NO; k++) begin
      int cyc = 0;
      while (!o_dout_valid && cyc < 200) begin
        @(negedge clk); cyc++;
      end
      checks++;
      if (!o_dout_valid || exp_data_q.size() == 0) begin
        errors++;
        $display("FAIL dout_wait: got valid=%0b queued=%0d, required valid result", o_dout_valid, exp_data_q.size());
        return;
      end
      ed = exp_data_q.pop_front();
      ei = exp_idx_q.pop_front();
      if (o_dout_data !== ed) begin
        errors++; $display("FAIL dout_data k=%0d: got %h, required %h", k, o_dout_data, ed);
      end
      checks++;
      if (o_dout_idx !== ei) begin
        errors++; $display("FAIL dout_idx: got %0d, required %0d", o_dout_idx, ei);
      end
      if (k == stall_k) begin
        for (int s = 0; s < 10; s++) begin
          i_start = poke_start && (s == 0);
          @(negedge clk);
          checks++;
          if (o_dout_valid !== 1'b1 || o_dout_data !== ed || o_dout_idx !== ei || o_w_rd !== 1'b0) begin
            errors++;
            $display("FAIL stall: got v=%0b d=%h i=%0d rd=%0b, required v=1 d=%h i=%0d rd=0",
                     o_dout_valid, o_dout_data, o_dout_idx, o_w_rd, ed, ei);
          end
        end
        i_start = 1'b0;
      end
      i_dout_ready = 1'b1;
      @(negedge clk);
      i_dout_ready = 1'b0;
      if (k == NO-1) begin
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0) begin
          errors++; $display("FAIL done_pulse: got done=%0b busy=%0b, required 1/0", o_done, o_busy);
        end
        @(negedge clk);
        checks++;
        if (o_done !== 1'b0) begin
          errors++; $display("FAIL done_width: got %0b, required 0", o_done);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({o_busy, o_done, o_dg_ready, o_w_rd, o_dout_valid} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b, required 00000", {o_busy, o_done, o_dg_ready, o_w_rd, o_dout_valid});
    end
    checks++;
    if (o_w_addr !== '0 || o_dout_data !== '0 || o_dout_idx !== '0) begin
      errors++; $display("FAIL reset_data: got %0d %h %0d, required 0 0 0", o_w_addr, o_dout_data, o_dout_idx);
    end
`ifdef BP_SAT_EN
    checks++;
    if (o_sat !== 1'b0) begin
      errors++; $display("FAIL reset_sat: got %0b, required 0", o_sat);
    end
`endif
  endtask

  task automatic test_const(input string name, input logic [WIDTH-1:0] exp_v);
    int d0 = done_cnt;
    push_addrs();
    push_const(exp_v);
    load_job(1'b0);
    collect(-1, 1'b0);
    checks++;
    if (done_cnt != d0 + 1 || exp_addr_q.size() != 0) begin
      errors++; $display("FAIL %s_end: got done=%0d addr_left=%0d, required 1 0", name, done_cnt - d0, exp_addr_q.size());
    end
  endtask

  task automatic test_unit_weights();
    for (int n = 0; n < NG; n++) dgv[n] = 24'h100000;
    for (int a = 0; a < NG*NO; a++) wmem[a] = 24'h080000;
    test_const("unit", 24'h400000);
  endtask

  task automatic test_negative();
    for (int n = 0; n < NG; n++) dgv[n] = WIDTH'(n * 32'h20000);
    for (int a = 0; a < NG*NO; a++) wmem[a] = 24'hF00000;
    test_const("neg", 24'hC80000);
  endtask

  task automatic test_saturate();
    for (int n = 0; n < NG; n++) dgv[n] = 24'h700000;
    for (int a = 0; a < NG*NO; a++) wmem[a] = 24'h700000;
`ifdef BP_SAT_EN
    test_const("sat", 24'h7FFFFF);
    checks++;
    if (o_sat !== 1'b1) begin
      errors++; $display("FAIL sat_flag: got %0b, required 1", o_sat);
    end
`else
    test_const("wrap", 24'h800000);
`endif
  endtask

  task automatic randomize_data();
    for (int n = 0; n < NG; n++) dgv[n] = WIDTH'($urandom);
    for (int a = 0; a < NG*NO; a++) wmem[a] = WIDTH'($urandom);
  endtask

  task automatic test_back_pressure();
    int d0 = done_cnt;
    // Stray dgate beats while idle must not be taken.
    i_dg_valid = 1'b1; i_dg_data = 24'h123456;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (o_dg_ready !== 1'b0 || o_busy !== 1'b0) begin
        errors++; $display("FAIL idle_dg: got ready=%0b busy=%0b, required 0/0", o_dg_ready, o_busy);
      end
    end
    i_dg_valid = 1'b0;
    randomize_data();
    push_addrs();
    push_model();
    load_job(1'b1);
`ifdef BP_SAT_EN
    checks++;
    if (o_sat !== 1'b0) begin
      errors++; $display("FAIL sat_clear: got %0b, required 0", o_sat);
    end
`endif
    collect(1, 1'b1);
    checks++;
    if (done_cnt != d0 + 1 || o_busy !== 1'b0) begin
      errors++; $display("FAIL bp_end: got done=%0d busy=%0b, required 1 0", done_cnt - d0, o_busy);
    end
  endtask

  task automatic test_abort();
    int d0;
    int cyc = 0;
    randomize_data();
    push_addrs();
    push_model();
    load_job(1'b0);
    while (!o_dout_valid && cyc < 200) begin
      @(negedge clk); cyc++;
    end
    i_dout_ready = 1'b1;
    @(negedge clk);
    i_dout_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (o_w_rd !== 1'b1 || o_busy !== 1'b1) begin
      errors++; $display("FAIL abort_pre: got rd=%0b busy=%0b, required 1/1", o_w_rd, o_busy);
    end
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_busy, o_done, o_dg_ready, o_w_rd, o_dout_valid} !== 5'b0 ||
        o_w_addr !== '0 || o_dout_data !== '0 || o_dout_idx !== '0) begin
      errors++; $display("FAIL abort_outputs: got ctrl=%b addr=%0d data=%h idx=%0d, required all 0",
                         {o_busy, o_done, o_dg_ready, o_w_rd, o_dout_valid}, o_w_addr, o_dout_data, o_dout_idx);
    end
    rst = 1'b0;
    exp_addr_q.delete(); exp_data_q.delete(); exp_idx_q.delete();
    @(negedge clk);
    checks++;
    if (done_cnt != d0) begin
      errors++; $display("FAIL abort_done: got %0d pulses, required 0", done_cnt - d0);
    end
    randomize_data();
    push_addrs();
    push_model();
    load_job(1'b0);
    collect(-1, 1'b0);
    checks++;
    if (done_cnt != d0 + 1 || exp_addr_q.size() != 0) begin
      errors++; $display("FAIL abort_rerun: got done=%0d addr_left=%0d, required 1 0", done_cnt - d0, exp_addr_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_unit_weights();
    test_negative();
    test_saturate();
    test_back_pressure();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
